// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register word offsets, CTRL bit
// positions and the encoding of the VALUE read wait-state machine.
package apb_timer_pkg;

   localparam logic [5:0] ADDR_CTRL    = 6'd0;
   localparam logic [5:0] ADDR_LOAD    = 6'd1;
   localparam logic [5:0] ADDR_VALUE   = 6'd2;
   localparam logic [5:0] ADDR_INTSTAT = 6'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_PRE_LSB = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } rd_state_t;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescale counter: counts 0..i_prescale while enabled and emits a one-cycle
// tick on the wrap cycle, so the tick period is i_prescale+1 clocks.
module apb_timer_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [PRE_W-1:0] i_prescale,
   output logic             o_tick
);

   logic [PRE_W-1:0] r_cnt;
   logic             w_wrap;

   // >= rather than == so a prescale lowered below the current count wraps at once.
   assign w_wrap = (r_cnt >= i_prescale);
   assign o_tick = i_en & w_wrap;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge PCLK) begin
      if (!PRESETn || i_clr || !i_en) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PRE_W'(1);
      end
   end

endmodule

// File: rtl/apb_timer.sv
// APB responder wrapping a 32-bit down-counting timer with prescaler,
// periodic/one-shot modes and a level interrupt.
module apb_timer
   import apb_timer_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PRE_W = 8
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic [5:0]  PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        TIMERINT
);

   logic             r_en;
   logic             r_ie;
   logic             r_oneshot;
   logic [PRE_W-1:0] r_prescale;
   logic [CNT_W-1:0] r_load;
   logic [CNT_W-1:0] r_value;
   logic [CNT_W-1:0] r_hold;
   logic             r_flag;
   rd_state_t        r_state;

   logic w_access;
   logic w_value_rd;
   logic w_wr;
   logic w_bad_addr;
   logic w_ctrl_wr;
   logic w_load_wr;
   logic w_int_wr;
   logic w_tick_raw;
   logic w_tick;

   assign w_access   = PSEL & PENABLE;
   assign w_value_rd = w_access & ~PWRITE & (PADDR == ADDR_VALUE);
   assign w_bad_addr = (PADDR > ADDR_INTSTAT);

   assign PREADY  = ~((r_state == ST_IDLE) & w_value_rd);
   assign PSLVERR = w_access & PREADY & w_bad_addr;

   assign w_wr      = w_access & PWRITE & PREADY;
   assign w_ctrl_wr = w_wr & (PADDR == ADDR_CTRL);
   assign w_load_wr = w_wr & (PADDR == ADDR_LOAD);
   assign w_int_wr  = w_wr & (PADDR == ADDR_INTSTAT);

   apb_timer_prescaler #(
      .PRE_W(PRE_W)
   ) u_prescaler (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .i_en      (r_en),
      .i_clr     (w_load_wr),
      .i_prescale(r_prescale),
      .o_tick    (w_tick_raw)
   );

   // A LOAD write restarts the count, so a tick landing on the same edge is dropped.
   assign w_tick = w_tick_raw & ~w_load_wr;

   // VALUE is captured on the wait cycle so the completing beat sees a stable word.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_value_rd) begin
                  r_state <= ST_WAIT;
                  r_hold  <= r_value;
               end
            end
            ST_WAIT: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_en       <= 1'b0;
         r_ie       <= 1'b0;
         r_oneshot  <= 1'b0;
         r_prescale <= '0;
         r_load     <= '0;
         r_value    <= '0;
         r_flag     <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_en       <= PWDATA[CTRL_EN];
            r_ie       <= PWDATA[CTRL_IE];
            r_oneshot  <= PWDATA[CTRL_ONESHOT];
            r_prescale <= PWDATA[CTRL_PRE_LSB +: PRE_W];
         end
         if (w_int_wr && PWDATA[0]) begin
            r_flag <= 1'b0;
         end
         // Tick effects come after the bus writes: a zero-tick beats an INTSTAT
         // clear, and a one-shot expiry beats a simultaneous CTRL write of EN.
         if (w_load_wr) begin
            r_load  <= PWDATA[CNT_W-1:0];
            r_value <= PWDATA[CNT_W-1:0];
         end else if (w_tick) begin
            if (r_value != '0) begin
               r_value <= r_value - CNT_W'(1);
            end else begin
               r_flag <= 1'b1;
               if (r_oneshot) begin
                  r_en <= 1'b0;
               end else begin
                  r_value <= r_load;
               end
            end
         end
      end
   end

   assign TIMERINT = r_flag & r_ie;

   // NOTE: PRDATA gets a default before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (PADDR)
            ADDR_CTRL: begin
               PRDATA[CTRL_EN]                   = r_en;
               PRDATA[CTRL_IE]                   = r_ie;
               PRDATA[CTRL_ONESHOT]              = r_oneshot;
               PRDATA[CTRL_PRE_LSB +: PRE_W]     = r_prescale;
            end
            ADDR_LOAD:    PRDATA = 32'(r_load);
            ADDR_VALUE:   PRDATA = (r_state == ST_WAIT) ? 32'(r_hold) : 32'(r_value);
            ADDR_INTSTAT: PRDATA[0] = r_flag;
            default:      PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed scenarios plus randomized timer
// configurations compared against a closed-form tick-count model.
module tb_apb_timer;
   import apb_timer_pkg::*;

   logic        PCLK    = 1'b0;
   logic        PRESETn = 1'b0;
   logic        PSEL    = 1'b0;
   logic [5:0]  PADDR   = '0;
   logic        PENABLE = 1'b0;
   logic        PWRITE  = 1'b0;
   logic [31:0] PWDATA  = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        TIMERINT;

   apb_timer #(.CNT_W(32), .PRE_W(8)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSEL    (PSEL),
      .PADDR   (PADDR),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .TIMERINT(TIMERINT)
   );

   always #5 PCLK = ~PCLK;

   // Edge counter: after edge k (plus #1) cyc == k.
   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;
   int last_eff;

   // Reference model: timer enabled at edge m_e0 with load m_L and prescale m_P;
   // ticks fall on edges m_e0 + j*(m_P+1); flag clears at edge m_clr.
   int m_e0, m_L, m_P, m_clr;
   bit m_run, m_os, m_ie;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ticks_at(input int e);
      int t;
      if (!m_run || e <= m_e0) return 0;
      t = (e - m_e0) / (m_P + 1);
      if (m_os && t > m_L + 1) t = m_L + 1;
      return t;
   endfunction

   function automatic logic [31:0] value_at(input int e);
      int t;
      t = ticks_at(e);
      if (m_os) return (t <= m_L) ? 32'(m_L - t) : 32'd0;
      return 32'(m_L - (t % (m_L + 1)));
   endfunction

   function automatic bit flag_at(input int e);
      int t;
      bit sets;
      t = ticks_at(e);
      for (int j = 1; j <= t; j++) begin
         sets = m_os ? (j == m_L + 1) : ((j % (m_L + 1)) == 0);
         if (sets && (m_e0 + j * (m_P + 1) >= m_clr)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] ctrl_at(input int e);
      logic [31:0] r;
      r       = '0;
      r[0]    = m_run && (!m_os || ticks_at(e) < m_L + 1);
      r[1]    = m_ie;
      r[2]    = m_os;
      r[15:8] = m_P[7:0];
      return r;
   endfunction

   function automatic logic [31:0] exp_reg(input logic [5:0] a, input int e);
      case (a)
         ADDR_CTRL:    return ctrl_at(e);
         ADDR_LOAD:    return 32'(m_L);
         ADDR_VALUE:   return value_at(e);
         ADDR_INTSTAT: return 32'(flag_at(e));
         default:      return 32'd0;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic apb_write(input logic [5:0] a, input logic [31:0] d,
                            output int eff, output logic err);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      err = PSLVERR;
      @(posedge PCLK); #1;
      eff = cyc;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic err,
                           output int waits, output int snap);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      snap  = cyc;
      waits = 0;
      @(negedge PCLK);
      while (PREADY !== 1'b1 && waits < 4) begin
         waits++;
         @(negedge PCLK);
      end
      d   = PRDATA;
      err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      logic err;
      apb_write(a, d, last_eff, err);
      check("wr_slverr", 32'(err), 32'(a > ADDR_INTSTAT));
   endtask

   task automatic rd_check(input logic [5:0] a, input string tag);
      logic [31:0] d;
      logic        err;
      int          waits, snap;
      apb_read(a, d, err, waits, snap);
      check({tag, "_data"}, d, exp_reg(a, snap));
      check({tag, "_slverr"}, 32'(err), 32'(a > ADDR_INTSTAT));
      check({tag, "_waits"}, 32'(waits), (a == ADDR_VALUE) ? 32'd1 : 32'd0);
   endtask

   task automatic irq_check(input string tag);
      check(tag, 32'(TIMERINT), 32'(m_ie & flag_at(cyc)));
   endtask

   task automatic model_idle();
      m_run = 1'b0; m_os = 1'b0; m_ie = 1'b0; m_P = 0; m_clr = 0; m_e0 = 0;
   endtask

   task automatic start_timer(input int l, input int p, input bit os, input bit ie);
      wr(ADDR_CTRL, 32'd0);
      model_idle();
      wr(ADDR_INTSTAT, 32'd1);
      wr(ADDR_LOAD, 32'(l));
      m_L = l;
      wr(ADDR_CTRL, (32'(p) << 8) | (32'(os) << 2) | (32'(ie) << 1) | 32'd1);
      m_e0 = last_eff; m_P = p; m_os = os; m_ie = ie; m_run = 1'b1; m_clr = 0;
   endtask

   // Idle until a write issued now would take effect on an edge with the given phase.
   task automatic align(input int modv, input int rem);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         if (((cyc + 2 - m_e0) % modv) == rem) found = 1'b1;
         else idle(1);
      end
      if (!found) begin
         n_chk++;
         n_fail++;
         $error("FAIL align: observed no phase %0d expected phase found", rem);
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        err;
      int          waits, snap;

      // Reset state
      m_L = 0;
      model_idle();
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_pready", 32'(PREADY), 32'd1);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_timerint", 32'(TIMERINT), 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      PRESETn = 1'b1;
      idle(1);
      for (int a = 0; a < 4; a++) rd_check(6'(a), "reset_rd");

      // Periodic, LOAD=3, prescale 0: flag on the 4th tick, then every 4 cycles
      start_timer(3, 0, 1'b0, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         idle(1);
         irq_check("per_irq");
      end
      repeat (3) rd_check(ADDR_VALUE, "per_value");

      // INTSTAT clear on the same edge as a zero-tick: the set wins
      align(4, 0);
      wr(ADDR_INTSTAT, 32'd1);
      m_clr = last_eff;
      check("clr_vs_set", 32'(TIMERINT), 32'd1);
      align(4, 1);
      wr(ADDR_INTSTAT, 32'd1);
      m_clr = last_eff;
      check("clr_alone", 32'(TIMERINT), 32'd0);
      idle(3);
      irq_check("per_reassert");
      rd_check(ADDR_INTSTAT, "per_intstat");
      rd_check(ADDR_CTRL, "per_ctrl");

      // One-shot, LOAD=2, prescale 1
      start_timer(2, 1, 1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         idle(1);
         irq_check("os_irq");
      end
      check("os_irq_set", 32'(TIMERINT), 32'd1);
      rd_check(ADDR_CTRL, "os_ctrl");
      rd_check(ADDR_VALUE, "os_value");
      rd_check(ADDR_INTSTAT, "os_intstat");
      idle(4);
      rd_check(ADDR_VALUE, "os_hold");
      wr(ADDR_INTSTAT, 32'd1);
      m_clr = last_eff;
      check("os_irq_clr", 32'(TIMERINT), 32'd0);

      // Out-of-range address: error response, no side effects
      wr(ADDR_CTRL, 32'd0);
      model_idle();
      wr(ADDR_LOAD, 32'h55);
      m_L = 32'h55;
      wr(6'd5, 32'hFFFF);
      rd_check(6'd5, "bad_rd");
      for (int a = 0; a < 4; a++) rd_check(6'(a), "bad_regs");

      // Randomized configurations against the model
      for (int trial = 0; trial < 10; trial++) begin
         start_timer(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int s = 0; s < 5; s++) begin
            idle(int'($urandom_range(0, 10)));
            irq_check("rnd_irq");
            if ($urandom_range(0, 3) == 0) begin
               wr(ADDR_INTSTAT, 32'd1);
               m_clr = last_eff;
            end else begin
               rd_check(6'($urandom_range(0, 3)), "rnd_rd");
            end
         end
      end

      // LOAD write while running discards the coincident tick, then reset mid-count
      start_timer(0, 0, 1'b0, 1'b1);
      idle(2);
      check("lz_irq", 32'(TIMERINT), 32'd1);
      wr(ADDR_LOAD, 32'h10);
      apb_read(ADDR_VALUE, d, err, waits, snap);
      check("load_wins", d, 32'h0F);
      PRESETn = 1'b0;
      idle(1);
      check("midrst_timerint", 32'(TIMERINT), 32'd0);
      check("midrst_pready", 32'(PREADY), 32'd1);
      PRESETn = 1'b1;
      m_L = 0;
      model_idle();
      for (int a = 0; a < 4; a++) rd_check(6'(a), "midrst_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
